// File: rtl/ita_softmax_requant_fifo.sv
// First-word-fall-through vector FIFO between the requantizer and the softmax unit.
// Optional sticky overflow/underflow flags and misuse assertions: define ITA_SOFTMAX_FIFO_ERR_EN.
module ita_softmax_requant_fifo #(
   parameter int unsigned N         = 16,
   parameter int unsigned WO        = 8,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned AF_THRESH = 12
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       push_valid_i,
   output logic                       push_ready_o,
   input  logic [N*WO-1:0]            push_data_i,
   input  logic                       pop_i,
   output logic                       pop_valid_o,
   output logic [N*WO-1:0]            pop_data_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       almost_full_o,
   output logic                       empty_o
`ifdef ITA_SOFTMAX_FIFO_ERR_EN
   ,
   output logic                       overflow_o,
   output logic                       underflow_o
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned DW    = N * WO;

   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [PTR_W:0]   PTR_ONE     = (PTR_W + 1)'(1);
   localparam logic [CNT_W-1:0] AF_THRESH_C = CNT_W'(AF_THRESH);

   logic [DW-1:0]      mem_q [DEPTH];
   logic [DW-1:0]      mem_d [DEPTH];
   logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;

   logic full, empty, push_fire, pop_fire;

   // Pointer MSB is the wrap bit; equal indices with differing wrap bits means full.
   assign full  = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                  (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
   assign empty = (wr_ptr_q == rd_ptr_q);

   assign push_fire = push_valid_i & ~full;
   assign pop_fire  = pop_i & ~empty;

   assign push_ready_o  = ~full;
   assign pop_valid_o   = ~empty;
   assign pop_data_o    = empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];
   assign count_o       = count_q;
   assign almost_full_o = (count_q >= AF_THRESH_C);
   assign empty_o       = (count_q == '0);

   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_fire) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = push_data_i;
            wr_ptr_d                   = wr_ptr_q + PTR_ONE;
         end
         if (pop_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         case ({push_fire, pop_fire})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; pop_data_o is gated to zero while empty instead.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

`ifdef ITA_SOFTMAX_FIFO_ERR_EN
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;

   always_comb begin
      overflow_d  = overflow_q | (push_valid_i & full);
      underflow_d = underflow_q | (pop_i & empty);
      if (flush_i) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign overflow_o  = overflow_q;
   assign underflow_o = underflow_q;

   // Misuse is reported as a warning; the sticky flags carry the hard error indication.
   a_no_push_full : assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
      !(push_valid_i && full)) else $warning("push while full");
   a_no_pop_empty : assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
      !(pop_i && empty)) else $warning("pop while empty");
`endif

endmodule
